// File: rtl/aes_host_if.sv
// ----------------------------------------------------------------------------
// aes_host_if
//
// Host-side loader/unloader for an AES_ENC or AES_DEC core. The host writes
// 32-bit words that are assembled big-endian into the 128-bit key and data
// blocks. The block then sequences the core's Krdy/Drdy handshake around BSY,
// captures Dout on Dvld and hands the result back as four 32-bit words.
//
// Optional feature (macro AES_HOST_IF_TIMEOUT_EN): abort a RUN that sees no
// aes_dvld within TIMEOUT cycles of aes_drdy and raise a sticky err flag.
// Without the macro there is no counter, err is tied 0 and RUN waits forever.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   wr_vld/wr_sel/      host write strobe, 0 = key word / 1 = data word,
//   wr_data/wr_rdy      write word, write accepted when wr_vld && wr_rdy
//   rd_vld/rd_data/     result word valid, result word,
//   rd_ack              host pops the current result word
//   busy                high in any state other than IDLE
//   err                 sticky timeout flag
//   aes_en              core enable, high from the first cycle after reset
//   aes_key/aes_krdy    key to core, one-cycle key-ready pulse
//   aes_din/aes_drdy    data block to core, one-cycle data-ready pulse
//   aes_dout/aes_bsy/   core result, core busy, core result valid
//   aes_dvld
// ----------------------------------------------------------------------------
module aes_host_if #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         wr_vld,
    input  logic         wr_sel,
    input  logic [31:0]  wr_data,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [31:0]  rd_data,
    input  logic         rd_ack,
    output logic         busy,
    output logic         err,
    output logic         aes_en,
    output logic [127:0] aes_key,
    output logic         aes_krdy,
    output logic [127:0] aes_din,
    output logic         aes_drdy,
    input  logic [127:0] aes_dout,
    input  logic         aes_bsy,
    input  logic         aes_dvld
);

    typedef enum logic [2:0] {IDLE, KSET, DSET, RUN, OUT} state_t;

    state_t       state;
    logic [1:0]   kcnt;
    logic [1:0]   dcnt;
    logic [1:0]   rcnt;
    logic [1:0]   rcnt_nxt;
    logic         key_ok;
    logic         krdy_q;     // aes_krdy was high last cycle
    logic [127:0] result;
    logic         wr_fire;
    logic         rd_fire;

    assign wr_rdy   = (state == IDLE) && (!wr_sel || key_ok);
    assign wr_fire  = wr_vld && wr_rdy;
    assign rd_fire  = rd_vld && rd_ack;
    assign rcnt_nxt = rcnt + 2'd1;
    assign busy     = (state != IDLE);

    // The pulses are decoded from state and the live aes_bsy so they fire in
    // the first cycle the core is free: 4th word accepted at N -> pulse at N+1.
    // Drdy is also held off for the cycle right after a Krdy pulse.
    assign aes_krdy = (state == KSET) && !aes_bsy;
    assign aes_drdy = (state == DSET) && !aes_bsy && !krdy_q;

`ifdef AES_HOST_IF_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic            err_q;
    assign err = err_q;
`else
    logic unused_cfg;
    assign err        = 1'b0;
    assign unused_cfg = ^{TIMEOUT, TO_W};
`endif

    // Word i of a block lives at [127-32*i -: 32]; {~i, 5'b0} is that LSB.
    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            kcnt    <= '0;
            dcnt    <= '0;
            rcnt    <= '0;
            key_ok  <= 1'b0;
            krdy_q  <= 1'b0;
            aes_en  <= 1'b0;
            aes_key <= '0;
            aes_din <= '0;
            result  <= '0;
            rd_data <= '0;
            rd_vld  <= 1'b0;
`ifdef AES_HOST_IF_TIMEOUT_EN
            to_cnt  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            aes_en <= 1'b1;
            krdy_q <= aes_krdy;
            case (state)
                IDLE: begin
                    if (wr_fire) begin
                        if (!wr_sel) begin
                            aes_key[{~kcnt, 5'b00000} +: 32] <= wr_data;
                            kcnt   <= kcnt + 2'd1;
                            key_ok <= 1'b0;
                            if (kcnt == 2'd3) state <= KSET;
                        end else begin
                            aes_din[{~dcnt, 5'b00000} +: 32] <= wr_data;
                            dcnt <= dcnt + 2'd1;
                            if (dcnt == 2'd3) state <= DSET;
                        end
                    end
                end
                KSET: begin
                    if (aes_krdy) begin
                        key_ok <= 1'b1;
                        state  <= IDLE;
                    end
                end
                DSET: begin
                    if (aes_drdy) begin
                        state <= RUN;
`ifdef AES_HOST_IF_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end
                RUN: begin
                    // A result in the same cycle the count expires still wins.
                    if (aes_dvld) begin
                        result  <= aes_dout;
                        rd_data <= aes_dout[127:96];
                        rd_vld  <= 1'b1;
                        rcnt    <= '0;
                        state   <= OUT;
                    end
`ifdef AES_HOST_IF_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        dcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                OUT: begin
                    if (rd_fire) begin
                        if (rcnt == 2'd3) begin
                            rd_vld <= 1'b0;
                            rcnt   <= '0;
                            state  <= IDLE;
                        end else begin
                            rcnt    <= rcnt_nxt;
                            rd_data <= result[{~rcnt_nxt, 5'b00000} +: 32];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_host_if.sv
// ----------------------------------------------------------------------------
// tb_aes_host_if
//
// Self-checking bench for aes_host_if. A small core model answers each
// aes_drdy with aes_dvld after core_lat cycles, returning core_result.
// Expected host read words are pushed to exp_q when a block is issued and
// popped as the DUT presents them. Build with +define+AES_HOST_IF_TIMEOUT_EN
// to exercise the timeout abort instead of the indefinite RUN wait.
// ----------------------------------------------------------------------------
module tb_aes_host_if;

    logic         CLK = 1'b0;
    logic         RST;
    logic         wr_vld;
    logic         wr_sel;
    logic [31:0]  wr_data;
    logic         wr_rdy;
    logic         rd_vld;
    logic [31:0]  rd_data;
    logic         rd_ack;
    logic         busy;
    logic         err;
    logic         aes_en;
    logic [127:0] aes_key;
    logic         aes_krdy;
    logic [127:0] aes_din;
    logic         aes_drdy;
    logic [127:0] aes_dout;
    logic         aes_bsy;
    logic         aes_dvld;

    int checks = 0;
    int errors = 0;

    logic [31:0]  exp_q[$];
    logic [127:0] core_result;
    int           core_lat;
    bit           core_on;
    int           krdy_cnt = 0;
    int           drdy_cnt = 0;

    aes_host_if #(.TIMEOUT(8), .TO_W(7)) dut (
        .CLK(CLK), .RST(RST),
        .wr_vld(wr_vld), .wr_sel(wr_sel), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .rd_vld(rd_vld), .rd_data(rd_data), .rd_ack(rd_ack),
        .busy(busy), .err(err), .aes_en(aes_en),
        .aes_key(aes_key), .aes_krdy(aes_krdy),
        .aes_din(aes_din), .aes_drdy(aes_drdy),
        .aes_dout(aes_dout), .aes_bsy(aes_bsy), .aes_dvld(aes_dvld)
    );

    always #5 CLK = ~CLK;

    // Pulse counters, sampled mid-cycle.
    always @(negedge CLK) begin
        if (aes_krdy) krdy_cnt <= krdy_cnt + 1;
        if (aes_drdy) drdy_cnt <= drdy_cnt + 1;
    end

    // Core model: Dvld for one cycle, core_lat cycles after Drdy.
    initial begin
        aes_dvld = 1'b0;
        aes_dout = '0;
        forever begin
            @(negedge CLK);
            if (aes_drdy && core_on) begin
                repeat (core_lat) @(posedge CLK);
                #1;
                aes_dvld = 1'b1;
                aes_dout = core_result;
                @(posedge CLK);
                #1;
                aes_dvld = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push_block(input logic [127:0] blk);
        for (int i = 0; i < 4; i++) exp_q.push_back(blk[127 - 32*i -: 32]);
    endtask

    // Holds one word until accepted; returns just after the accepting edge.
    task automatic write_word(input logic sel, input logic [31:0] d);
        int n = 0;
        wr_vld = 1'b1;
        wr_sel = sel;
        wr_data = d;
        @(negedge CLK);
        while (!wr_rdy && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!wr_rdy) begin
            errors++;
            $display("FAIL write_accept: wr_rdy=%b after %0d cycles, required 1", wr_rdy, n);
        end
        @(posedge CLK);
        #1;
        wr_vld = 1'b0;
    endtask

    task automatic write_block(input logic sel, input logic [127:0] blk);
        for (int i = 0; i < 4; i++) write_word(sel, blk[127 - 32*i -: 32]);
    endtask

    // Pops four result words, acking each with `gap` idle cycles between.
    task automatic read_block(input int gap);
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            @(negedge CLK);
            while (!rd_vld && n < 100) begin
                @(negedge CLK);
                n++;
            end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            checks++;
            if (!rd_vld || rd_data !== exp) begin
                errors++;
                $display("FAIL rd_word%0d: rd_vld=%b rd_data=%h, required 1/%h", i, rd_vld, rd_data, exp);
            end
            rd_ack = 1'b1;
            @(posedge CLK);
            #1;
            rd_ack = 1'b0;
            tick(gap);
        end
        @(negedge CLK);
        checks++;
        if (rd_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_done: rd_vld=%b busy=%b, required 0/0", rd_vld, busy);
        end
        tick(1);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        wr_vld = 1'b0; wr_sel = 1'b0; wr_data = '0; rd_ack = 1'b0; aes_bsy = 1'b0;
        core_on = 1'b1; core_lat = 3; core_result = '0;
        tick(3);
        @(negedge CLK);
        checks++;
        if ({busy, rd_vld, err, aes_krdy, aes_drdy, aes_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: busy,rd_vld,err,krdy,drdy,en=%b, required 000000",
                     {busy, rd_vld, err, aes_krdy, aes_drdy, aes_en});
        end
        checks++;
        if (aes_key !== '0 || aes_din !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_regs: key=%h din=%h rd_data=%h, required all 0", aes_key, aes_din, rd_data);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        tick(1);
        @(negedge CLK);
        checks++;
        if (aes_en !== 1'b1) begin
            errors++;
            $display("FAIL aes_en: got %b, required 1", aes_en);
        end
        tick(1);
    endtask

    task automatic test_data_before_key();
        int bad = 0;
        int d0 = drdy_cnt;
        wr_vld = 1'b1; wr_sel = 1'b1; wr_data = 32'hdead_beef;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (wr_rdy !== 1'b0) bad++;
            tick(1);
        end
        wr_vld = 1'b0;
        tick(2);
        checks++;
        if (bad != 0 || drdy_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL data_before_key: wr_rdy high %0d times, drdy pulses %0d, busy=%b, required 0/0/0",
                     bad, drdy_cnt - d0, busy);
        end
    endtask

    // Load key, check Krdy timing, run one block through the core model.
    task automatic run_fips(input string nm, input logic [127:0] key,
                            input logic [127:0] din, input logic [127:0] res);
        int k0 = krdy_cnt;
        core_result = res;
        core_lat = 3;
        push_block(res);
        write_block(1'b0, key);
        @(negedge CLK);
        checks++;
        if (aes_krdy !== 1'b1 || aes_key !== key) begin
            errors++;
            $display("FAIL %s_krdy: krdy=%b key=%h, required 1/%h", nm, aes_krdy, aes_key, key);
        end
        tick(1);
        @(negedge CLK);
        checks++;
        if (aes_krdy !== 1'b0 || krdy_cnt != k0 + 1) begin
            errors++;
            $display("FAIL %s_krdy_width: krdy=%b pulses=%0d, required 0/1", nm, aes_krdy, krdy_cnt - k0);
        end
        tick(1);
        write_block(1'b1, din);
        @(negedge CLK);
        checks++;
        if (aes_drdy !== 1'b1 || aes_din !== din) begin
            errors++;
            $display("FAIL %s_drdy: drdy=%b din=%h, required 1/%h", nm, aes_drdy, aes_din, din);
        end
        tick(1);
        @(negedge CLK);
        checks++;
        if (aes_drdy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drdy_width: drdy=%b, required 0", nm, aes_drdy);
        end
        tick(1);
        read_block(0);
    endtask

    task automatic test_encrypt();
        run_fips("enc", 128'h000102030405060708090a0b0c0d0e0f,
                 128'h00112233445566778899aabbccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    endtask

    task automatic test_decrypt();
        run_fips("dec", 128'h13111d7fe3944a17f307a78b4d2b30c5,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                 128'h00112233445566778899aabbccddeeff);
    endtask

    task automatic test_bsy_backpressure();
        int bad = 0;
        int d0 = drdy_cnt;
        core_result = 128'hcafef00d_01234567_89abcdef_5a5aa5a5;
        push_block(core_result);
        aes_bsy = 1'b1;
        write_block(1'b1, 128'h11111111_22222222_33333333_44444444);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (aes_drdy !== 1'b0 || busy !== 1'b1) bad++;
            tick(1);
        end
        aes_bsy = 1'b0;
        @(negedge CLK);
        checks++;
        if (bad != 0 || aes_drdy !== 1'b1) begin
            errors++;
            $display("FAIL bsy_hold: drdy early %0d times, drdy at release=%b, required 0/1", bad, aes_drdy);
        end
        tick(1);
        @(negedge CLK);
        checks++;
        if (aes_drdy !== 1'b0 || drdy_cnt != d0 + 1) begin
            errors++;
            $display("FAIL bsy_drdy_width: drdy=%b pulses=%0d, required 0/1", aes_drdy, drdy_cnt - d0);
        end
        tick(1);
        read_block(0);
    endtask

    task automatic test_read_stall();
        int bad = 0;
        int n = 0;
        core_result = 128'h0badf00d_feedface_76543210_c3c3c3c3;
        push_block(core_result);
        write_block(1'b1, 128'ha0a0a0a0_b1b1b1b1_c2c2c2c2_d3d3d3d3);
        @(negedge CLK);
        while (!rd_vld && n < 100) begin
            @(negedge CLK);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            wr_sel = i[0];
            if (!rd_vld || rd_data !== exp_q[0] || wr_rdy !== 1'b0) bad++;
            @(negedge CLK);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL read_stall: %0d unstable/wr_rdy cycles, rd_data=%h, required 0/%h", bad, rd_data, exp_q[0]);
        end
        tick(1);
        read_block(3);
    endtask

    // One key word clears key_ok; the rest of the key restores it.
    task automatic test_key_reload();
        logic [127:0] k = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        write_word(1'b0, k[127:96]);
        wr_sel = 1'b1;
        @(negedge CLK);
        checks++;
        if (wr_rdy !== 1'b0) begin
            errors++;
            $display("FAIL key_ok_clear: wr_rdy=%b for data after key word, required 0", wr_rdy);
        end
        tick(1);
        write_word(1'b0, k[95:64]);
        write_word(1'b0, k[63:32]);
        write_word(1'b0, k[31:0]);
        @(negedge CLK);
        checks++;
        if (aes_krdy !== 1'b1 || aes_key !== k) begin
            errors++;
            $display("FAIL key_reload: krdy=%b key=%h, required 1/%h", aes_krdy, aes_key, k);
        end
        tick(2);
    endtask

    task automatic test_back_to_back();
        core_lat = 1;
        core_result = 128'h3925841d_02dc09fb_dc118597_196a0b32;
        push_block(core_result);
        write_block(1'b1, 128'h3243f6a8_885a308d_313198a2_e0370734);
        read_block(0);
        core_result = 128'h01020304_05060708_090a0b0c_0d0e0f10;
        push_block(core_result);
        write_block(1'b1, 128'hffffffff_00000000_ffffffff_00000000);
        read_block(1);
    endtask

`ifdef AES_HOST_IF_TIMEOUT_EN
    task automatic test_timeout();
        core_on = 1'b0;
        write_block(1'b1, 128'h55555555_66666666_77777777_88888888);
        @(negedge CLK);
        checks++;
        if (aes_drdy !== 1'b1) begin
            errors++;
            $display("FAIL to_drdy: drdy=%b, required 1", aes_drdy);
        end
        tick(8);
        @(negedge CLK);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early: err=%b busy=%b at 8 RUN cycles, required 0/1", err, busy);
        end
        tick(1);
        @(negedge CLK);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL to_abort: err=%b busy=%b, required 1/0", err, busy);
        end
        tick(6);
        @(negedge CLK);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: err=%b, required 1", err);
        end
        tick(1);
        RST = 1'b1;
        tick(2);
        @(negedge CLK);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL to_rst_clear: err=%b, required 0", err);
        end
        tick(1);
        RST = 1'b0;
        core_on = 1'b1;
        tick(2);
    endtask
`else
    task automatic test_run_wait();
        core_lat = 40;
        core_result = 128'h89abcdef_01234567_fedcba98_76543210;
        push_block(core_result);
        write_block(1'b1, 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc);
        tick(30);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL run_wait: busy=%b err=%b rd_vld=%b, required 1/0/0", busy, err, rd_vld);
        end
        tick(1);
        read_block(0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_data_before_key();
        test_encrypt();
        test_decrypt();
        test_bsy_backpressure();
        test_read_stall();
        test_key_reload();
        test_back_to_back();
`ifdef AES_HOST_IF_TIMEOUT_EN
        test_timeout();
`else
        test_run_wait();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
